// File: rtl/uart_ctrl_pkg.sv
// Shared UART control definitions: arbiter FSM states and default frame parameters.
// Imported by the TX arbiter and available to the UART TX itself.
package uart_ctrl_pkg;

    localparam int unsigned DefDataW       = 8;
    localparam int unsigned DefBusyTimeout = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWaitBusy,
        StWaitDone,
        StDone
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    always_comb begin : pick
        int unsigned w_pos;
        logic [IDX_W-1:0] w_idx;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        w_pos   = 0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_pos = 32'(ptr_i) + i;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_idx = IDX_W'(w_pos);
            if (!valid_o && req_i[w_idx]) begin
                valid_o      = 1'b1;
                gnt_o[w_idx] = 1'b1;
                idx_o        = w_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Sequences byte_ready/t_byte, tracks tx_busy_i, and flags a busy-timeout.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_W       = DefDataW,
    parameter int unsigned BUSY_TIMEOUT = DefBusyTimeout
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          done_o,
    output logic [DATA_W-1:0]           data_out_o,
    output logic                        byte_ready_o,
    output logic                        t_byte_o,
    input  logic                        tx_busy_i,
    output logic                        active_o,
    output logic [$clog2(NUM_REQ)-1:0]  owner_o,
    output logic                        err_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);

    state_e              r_state, w_state_next;
    logic [DATA_W-1:0]   r_data, w_data_next;
    logic [IdxW-1:0]     r_owner, w_owner_next;
    logic [IdxW-1:0]     r_ptr, w_ptr_next;
    logic [CntW-1:0]     r_cnt, w_cnt_next;
    logic                r_err, w_err_next;

    logic [NUM_REQ-1:0]  w_arb_gnt;
    logic [IdxW-1:0]     w_arb_idx;
    logic                w_arb_valid;
    logic [DATA_W-1:0]   w_arb_data;
    logic [IdxW-1:0]     w_ptr_wrap;
    logic [NUM_REQ-1:0]  w_owner_oh;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_rr_arbiter (
        .req_i   (req_i),
        .ptr_i   (r_ptr),
        .gnt_o   (w_arb_gnt),
        .idx_o   (w_arb_idx),
        .valid_o (w_arb_valid)
    );

    // One-hot AND-OR select of the winner's byte.
    always_comb begin
        w_arb_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_arb_gnt[k]) begin
                w_arb_data = w_arb_data | req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ptr_wrap = (r_owner == IdxW'(NUM_REQ - 1)) ? '0 : r_owner + IdxW'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= StIdle;
            r_data  <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_data  <= w_data_next;
            r_owner <= w_owner_next;
            r_ptr   <= w_ptr_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_data;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        w_err_next   = r_err;
        unique case (r_state)
            StIdle: begin
                if (w_arb_valid) begin
                    w_state_next = StLoad;
                    w_data_next  = w_arb_data;
                    w_owner_next = w_arb_idx;
                end
            end
            StLoad: w_state_next = StStart;
            StStart: begin
                // r_cnt holds cycles elapsed since the t_byte_o strobe.
                w_state_next = StWaitBusy;
                w_cnt_next   = CntW'(1);
            end
            StWaitBusy: begin
                if (tx_busy_i) begin
                    w_state_next = StWaitDone;
                end else if (r_cnt >= CntW'(BUSY_TIMEOUT - 1)) begin
                    w_state_next = StIdle;
                    w_err_next   = 1'b1;
                    w_ptr_next   = w_ptr_wrap;
                end else begin
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end
            StWaitDone: begin
                if (!tx_busy_i) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
                w_ptr_next   = w_ptr_wrap;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

    assign gnt_o        = (r_state == StLoad) ? w_owner_oh : '0;
    assign done_o       = (r_state == StDone) ? w_owner_oh : '0;
    assign byte_ready_o = (r_state == StLoad);
    assign t_byte_o     = (r_state == StStart);
    assign active_o     = (r_state != StIdle);
    assign data_out_o   = r_data;
    assign owner_o      = r_owner;
    assign err_o        = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a frame-level schedule model.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int BT   = 16;
    localparam int LEAD = 2;   // UART raises busy this many cycles after t_byte
    localparam int LEN  = 10;  // and holds it for this many cycles
    // Offsets from the IDLE sample cycle c: grant c+1, t_byte c+2, done after busy falls.
    localparam int DONE_OFF = 2 + LEAD + LEN + 1;
    localparam int BIG      = 1 << 30;

    logic            clk = 1'b0;
    logic            reset_i = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    gnt, done;
    logic [DW-1:0]   data_out;
    logic            byte_ready, t_byte, active, err;
    logic            tx_busy = 1'b0;
    logic [1:0]      owner;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .DATA_W       (DW),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req_i        (req),
        .req_data_i   (req_data),
        .gnt_o        (gnt),
        .done_o       (done),
        .data_out_o   (data_out),
        .byte_ready_o (byte_ready),
        .t_byte_o     (t_byte),
        .tx_busy_i    (tx_busy),
        .active_o     (active),
        .owner_o      (owner),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n = 0;
    bit checking = 0;
    bit rst_cmd = 1;
    bit uart_dead = 0;
    bit cont_all = 0;
    int arrive_pct = 0;
    int drop_pct = 0;
    int busy_start = -1000;
    logic [N-1:0] pend = '0;
    logic [7:0]   rdata [N];
    int gnt_log[$];
    int done_cnt [N];
    logic [7:0] br_data;

    // Reference model: one scheduled frame at a time.
    bit         m_frame = 0;
    bit         m_to = 0;
    int         m_c = 0;
    int         m_w = 0;
    int         m_free_at = 0;
    int         m_err_at = BIG;
    int         m_owner = 0;
    int         m_ptr = 0;
    logic [7:0] m_data = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    task automatic step();
        logic [N-1:0] e_gnt, e_done;
        bit in_fr, found;
        @(posedge clk);
        #1;
        n++;
        if (checking) begin
            in_fr  = m_frame && (n >= m_c + 1) && (n < m_free_at);
            e_gnt  = (m_frame && n == m_c + 1) ? (N'(1) << m_w) : '0;
            e_done = (m_frame && !m_to && n == m_c + DONE_OFF) ? (N'(1) << m_w) : '0;
            check_val("gnt", gnt, e_gnt);
            check_val("done", done, e_done);
            check_val("byte_ready", byte_ready, m_frame && n == m_c + 1);
            check_val("t_byte", t_byte, m_frame && n == m_c + 2);
            check_val("active", active, in_fr);
            check_val("data_out", data_out, m_data);
            check_val("owner", owner, m_owner);
            check_val("err", err, n >= m_err_at);
            for (int k = 0; k < N; k++) begin
                if (gnt[k]) gnt_log.push_back(k);
                if (done[k]) done_cnt[k]++;
            end
            if (byte_ready) br_data = data_out;
        end
        if (t_byte && !uart_dead) busy_start = n + LEAD;

        reset_i = rst_cmd;
        for (int k = 0; k < N; k++) begin
            if (!pend[k]) begin
                rdata[k] = 8'($urandom);
                if (cont_all || (arrive_pct > 0 && $urandom_range(99) < arrive_pct)) pend[k] = 1'b1;
            end else if (drop_pct > 0 && $urandom_range(99) < drop_pct) begin
                pend[k] = 1'b0;
            end
            req_data[k*DW +: DW] = rdata[k];
        end
        req = pend;
        if (rst_cmd) busy_start = -1000;
        tx_busy = !uart_dead && (n >= busy_start) && (n < busy_start + LEN);

        if (rst_cmd) begin
            m_frame   = 0;
            m_free_at = n + 1;
            m_data    = '0;
            m_owner   = 0;
            m_ptr     = 0;
            m_err_at  = BIG;
        end else if (n >= m_free_at && pend != '0) begin
            found = 0;
            for (int i = 0; i < N; i++) begin
                if (!found && pend[(m_ptr + i) % N]) begin
                    found = 1;
                    m_w   = (m_ptr + i) % N;
                end
            end
            m_frame   = 1;
            m_c       = n;
            m_to      = uart_dead;
            m_data    = rdata[m_w];
            m_owner   = m_w;
            m_ptr     = (m_w + 1) % N;
            m_free_at = uart_dead ? n + 2 + BT : n + DONE_OFF + 1;
            if (uart_dead && (n + 2 + BT < m_err_at)) m_err_at = n + 2 + BT;
            pend[m_w] = 1'b0;
        end
    endtask

    task automatic raise(input int k, input logic [7:0] d);
        pend[k]  = 1'b1;
        rdata[k] = d;
    endtask

    task automatic run_served(input int budget);
        int k;
        k = 0;
        while ((pend != '0 || n < m_free_at) && k < budget) begin
            step();
            k++;
        end
        check_val("served_in_budget", k < budget, 1);
    endtask

    task automatic do_reset();
        rst_cmd = 1;
        pend    = '0;
        step();
        step();
        rst_cmd = 0;
        gnt_log.delete();
        for (int k = 0; k < N; k++) done_cnt[k] = 0;
    endtask

    initial begin
        int k;
        for (int i = 0; i < N; i++) begin
            rdata[i]    = '0;
            done_cnt[i] = 0;
        end
        step();
        checking = 1;
        do_reset();

        // Single request.
        raise(0, 8'hAA);
        run_served(60);
        check_val("single_data", br_data, 8'hAA);
        check_val("single_done0", done_cnt[0], 1);

        // Contention 1011 from reset: order 0,1,3.
        do_reset();
        raise(0, 8'h11);
        raise(1, 8'h22);
        raise(3, 8'h33);
        run_served(120);
        check_val("cont_len", gnt_log.size(), 3);
        if (gnt_log.size() == 3) begin
            check_val("cont_ord0", gnt_log[0], 0);
            check_val("cont_ord1", gnt_log[1], 1);
            check_val("cont_ord2", gnt_log[2], 3);
        end
        check_val("cont_done0", done_cnt[0], 1);
        check_val("cont_done1", done_cnt[1], 1);
        check_val("cont_done2", done_cnt[2], 0);
        check_val("cont_done3", done_cnt[3], 1);

        // Fairness: everyone requesting continuously.
        do_reset();
        cont_all = 1;
        repeat (8 * (DONE_OFF + 1)) step();
        cont_all = 0;
        run_served(120);
        check_val("fair_len", gnt_log.size() >= 8, 1);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) check_val("fair_ord", gnt_log[i], i % N);

        // Busy timeout, then recovery with err sticky.
        uart_dead = 1;
        raise(2, 8'h5C);
        run_served(60);
        uart_dead = 0;
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        raise(3, 8'hC3);
        run_served(60);
        check_val("to_err_sticky", err, 1);
        check_val("to_done2", done_cnt[2], 0);
        check_val("to_done3", done_cnt[3], 1);

        // Reset while waiting for busy to fall.
        do_reset();
        raise(1, 8'h77);
        k = 0;
        while (!(m_frame && n == m_c + 8) && k < 40) begin
            step();
            k++;
        end
        check_val("mid_reach", k < 40, 1);
        rst_cmd = 1;
        raise(0, 8'h0F);
        raise(2, 8'hF0);
        step();
        rst_cmd = 0;
        gnt_log.delete();
        run_served(120);
        check_val("mid_first", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

        // Random traffic with drops and occasional dead UART.
        arrive_pct = 15;
        drop_pct   = 2;
        repeat (1500) begin
            if (n + 1 >= m_free_at) uart_dead = ($urandom_range(7) == 0);
            step();
        end
        arrive_pct = 0;
        drop_pct   = 0;
        uart_dead  = 0;
        run_served(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
